apb_slave_mem: RTL
==================

Name: apb_slave_mem

Overview:
- APB3 completer (responder) for the 2-slave APB bridge. Each slave instance sits behind one PSELx; the bridge's PADDR[8] picks the instance and PADDR[7:0] reaches this block.
- Holds a byte-wide register file. Inserts a programmable number of wait states through PREADY.
- Flags out-of-range accesses and broken protocol sequences on PSLVERR.

Parameters:
- ADDR_W, 8, width of the PADDR slice seen by the slave.
- DATA_W, 8, data width of PWDATA/PRDATA and of each memory word.
- DEPTH, 64, number of implemented words. Valid addresses are 0..DEPTH-1; DEPTH <= 2**ADDR_W.
- WAIT_CYCLES, 2, wait states inserted per transfer, 0..15. A value of 0 means a zero-wait transfer.

Ports:
- PCLK  in  1  clock; all state updates on its rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- PSEL  in  1  slave select from the bridge (PSEL1 or PSEL2).
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  word address.
- PWDATA  in  DATA_W  write data.
- PRDATA  out  DATA_W  read data. Valid only while PREADY=1 on a read; 0 at all other times.
- PREADY  out  1  transfer completes in the cycle where PSEL & PENABLE & PREADY.
- PSLVERR  out  1  error response. Meaningful only while PREADY=1; 0 at all other times.

Behaviour:
- Reset (PRESETn=0 at a PCLK edge):
  - state=IDLE, wait counter=0, captured addr/dir/data=0, all memory words=0.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - Reset overrides any transfer in progress; no write commits on that edge.
- State machine, states IDLE, ACCESS, ERR:
  - IDLE: PSEL=1 & PENABLE=0 at an edge means the setup phase. Capture PADDR, PWRITE, PWDATA, load cnt=WAIT_CYCLES, go to ACCESS.
  - IDLE: PSEL=1 & PENABLE=1 at an edge means access without setup. Go to ERR.
  - ACCESS: while PSEL & PENABLE and cnt!=0, decrement cnt each edge; PREADY=0.
  - ACCESS: PREADY=1 combinationally when state==ACCESS and cnt==0. At the completing edge (PSEL&PENABLE&PREADY), commit and go to IDLE.
  - ACCESS: PSEL=0 at any edge aborts. Go to IDLE with no write.
  - ACCESS: a new setup phase (PSEL=1, PENABLE=0) at any edge re-captures and reloads cnt (bridge restart); stay in ACCESS.
  - ERR: PREADY=1 and PSLVERR=1 for exactly one cycle, then IDLE. No memory change.
- Latency:
  - Setup edge to completion = 1 + WAIT_CYCLES access cycles.
  - WAIT_CYCLES=0 gives the standard 2-cycle APB transfer.
- Commit rules:
  - Write: mem[addr] <= captured PWDATA at the completing edge, only if addr < DEPTH.
  - Read: PRDATA = mem[addr] combinationally while PREADY=1.
- Errors:
  - Captured addr >= DEPTH: PSLVERR=1 together with PREADY.
  - Out-of-range write: discarded.
  - Out-of-range read: PRDATA=0.
- Signals are sampled only at edges. PWDATA or PADDR changes during ACCESS are ignored because the setup capture is used.
- Back-to-back transfers: completion edge in ACCESS → IDLE. The next setup cycle is accepted from IDLE on the following edge, so there are no dead cycles beyond the APB minimum.
- Width rule: cnt is 4 bits and saturates at 0 (never wraps).

Decomposition:
- Shared package apb_pkg holds:
  - State encoding localparams IDLE=2'd0, ACCESS=2'd1, ERR=2'd2.
  - Default ADDR_W/DATA_W.
  - The bridge-side PADDR select bit index (8).
- One sub-module, apb_regfile: DEPTH x DATA_W storage with synchronous reset, write enable, combinational read port.
- The FSM, wait counter and error logic stay in apb_slave_mem.

Test Plan:
- Zero-wait write then read (WAIT_CYCLES=0): write addr 0x05 data 0xA5, then read 0x05 → PREADY high in the first access cycle both times; read PRDATA=0xA5, PSLVERR=0.
- Wait states (WAIT_CYCLES=2): write 0x3F data 0x5A → PREADY low 2 access cycles, high in the 3rd; read 0x3F → 0x5A after the same 2 wait cycles.
- Out of range (DEPTH=64): write 0x40 data 0xFF → PREADY=1 with PSLVERR=1; read 0x40 → PSLVERR=1, PRDATA=0; read 0x00 still returns prior value.
- Protocol error: PSEL=1 & PENABLE=1 with no setup → one cycle of PREADY=1, PSLVERR=1; memory unchanged.
- Abort and reset: start write 0x10 data 0x77 (WAIT_CYCLES=2), drop PSEL in the 2nd access cycle → read 0x10 returns 0x00. Separately, assert PRESETn=0 during a wait state → next cycle PREADY=0, PRDATA=0, all words read 0.
- Back-to-back: writes to 0x01, 0x02, 0x03 with data 0x11/0x22/0x33 and no idle gaps → three completions; reads return the same values.

Source files
------------

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB slave types, state encoding and defaults
package apb_pkg;

    localparam int APB_ADDR_W  = 8;
    localparam int APB_DATA_W  = 8;
    localparam int APB_SEL_BIT = 8;
    localparam int CNT_W       = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] ERR    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = IDLE,
        ST_ACCESS = ACCESS,
        ST_ERR    = ERR
    } apb_state_e;

    // Wait counter never wraps below zero.
    function automatic logic [CNT_W-1:0] cnt_dec(input logic [CNT_W-1:0] c);
        return (c == '0) ? c : c - 1'b1;
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// rtl/apb_slave_mem_if.sv - APB3 bus bundle between bridge and one completer
interface apb_slave_mem_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();

    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );

endinterface

// File: rtl/apb_regfile.sv
// rtl/apb_regfile.sv - DEPTH x DATA_W storage, sync clear, combinational read
module apb_regfile #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 6
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB3 completer with register file, wait states and PSLVERR
module apb_slave_mem
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           PCLK,
    input  logic           PRESETn,
    apb_slave_mem_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    apb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              in_range;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              pready;
    logic              pslverr;
    logic [DATA_W-1:0] prdata;

    assign in_range = (32'(addr_q) < 32'(DEPTH));

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        write_d = write_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.PSEL && !bus.PENABLE) begin
                    addr_d  = bus.PADDR;
                    write_d = bus.PWRITE;
                    wdata_d = bus.PWDATA;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    state_d = ST_ACCESS;
                end else if (bus.PSEL && bus.PENABLE) begin
                    state_d = ST_ERR;
                end
            end

            ST_ACCESS: begin
                pready  = (cnt_q == '0);
                pslverr = pready && !in_range;
                if (pready && !write_q && in_range) begin
                    prdata = mem_rdata;
                end
                // A fresh setup phase here is a bridge restart: recapture everything.
                if (!bus.PSEL) begin
                    state_d = ST_IDLE;
                end else if (!bus.PENABLE) begin
                    addr_d  = bus.PADDR;
                    write_d = bus.PWRITE;
                    wdata_d = bus.PWDATA;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_dec(cnt_q);
                end else begin
                    mem_we  = write_q && in_range;
                    state_d = ST_IDLE;
                end
            end

            ST_ERR: begin
                pready  = 1'b1;
                pslverr = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    apb_regfile #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk_i   (PCLK),
        .rst_ni  (PRESETn),
        .we_i    (mem_we),
        .addr_i  (addr_q[IDX_W-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (mem_rdata)
    );

    assign bus.PREADY  = pready;
    assign bus.PSLVERR = pslverr;
    assign bus.PRDATA  = prdata;

endmodule
